pipelined_addsub: RTL
=====================

// Module: pipelined_addsub
// PURPOSE
//  Parametrised, pipelined two's-complement adder/subtractor; next generation of the datapath adder.
//  - Splits a WIDTH-bit add into STAGES equal chunks; carry ripples across pipeline registers.
//  - Adds subtract mode, signed/unsigned overflow, zero flag, a sideband tag and valid/ready flow control.
//  - Sits in the EX stage wherever a long adder would otherwise limit clock period (ALU, branch target, address calc).
// PARAMETERS
//  WIDTH   32  operand/result width; must be divisible by STAGES
//  STAGES  4   pipeline depth = latency in cycles; chunk width CW = WIDTH/STAGES; 1..WIDTH
//  TAG_W   5   sideband tag width (e.g. destination register index), carried unchanged
// PORTS
//  clk_i       in   1        clock, rising edge
//  rst_i       in   1        asynchronous reset, active-high
//  flush_i     in   1        drop all in-flight operations
//  valid_i     in   1        operand beat valid
//  ready_o     out  1        block can accept a beat this cycle
//  src1_i      in   WIDTH    operand A
//  src2_i      in   WIDTH    operand B
//  sub_i       in   1        0: A+B, 1: A-B
//  signed_i    in   1        selects overflow definition
//  tag_i       in   TAG_W    sideband tag
//  valid_o     out  1        result valid
//  ready_i     in   1        downstream accepts result
//  sum_o       out  WIDTH    result (mod 2^WIDTH)
//  carry_o     out  1        raw carry out of MSB
//  overflow_o  out  1        signed: carry-into-MSB ^ carry-out; unsigned add: carry-out; unsigned sub: ~carry-out
//  zero_o      out  1        sum_o == 0
//  tag_o       out  TAG_W    tag of the result beat
// BEHAVIOUR
//  - Reset (async, rst_i=1): all stage valid bits, sum_o, carry_o, overflow_o, zero_o, tag_o -> 0; valid_o=0.
//  - Subtract: B' = ~src2_i, carry-in = 1; add: B' = src2_i, carry-in = 0. Operation fixed at input time.
//  - Stage k (0..STAGES-1) adds chunk k of A and B' plus carry from stage k-1 (carry-in for k=0).
//  - Higher operand chunks are skewed through registers so each chunk meets its carry; low sum chunks delayed to align.
//  - Final stage computes carry into MSB and carry out; flags are derived combinationally from last-stage registers.
//  - Latency: beat accepted at edge N -> valid_o=1 after edge N+STAGES-1 (STAGES=1: result registered, visible after edge N).
//  - Throughput 1 beat/cycle when ready_i=1.
//  - Flow control: advance = ready_i | ~valid_o; whole pipe shifts when advance=1, holds otherwise.
//  - ready_o = advance & ~flush_i; accept = valid_i & ready_o. No bubble collapsing inside the pipe.
//  - valid_o/sum_o/flags/tag_o stable while valid_o=1 & ready_i=0; results exit strictly in input order.
//  - flush_i=1: all stage valid bits cleared at next edge; concurrent valid_i beat not accepted. Data regs may keep stale values.
//  - Reset mid-operation: in-flight beats lost, no partial result ever asserted.
//  - Wrap-around: sum is modulo 2^WIDTH; e.g. 0xFFFFFFFF+1 -> 0, carry_o=1, zero_o=1.
// STRUCTURE
//  - Package addsub_pkg: mode encodings (ADD/SUB), localparam CW, tag type.
//  - Sub-module addsub_stage: one CW-bit chunk adder + carry/valid/tag registers with hold enable.
//    Instantiated STAGES times by generate; the skew registers live in the top level.
// TESTING
//  1. Signed add 0x7FFFFFFF+0x00000001 -> after 4 cycles sum_o=0x80000000, overflow_o=1, carry_o=0.
//  2. Unsigned sub 5-7 -> sum_o=0xFFFFFFFE, carry_o=0, overflow_o=1 (borrow); signed same op -> overflow_o=0.
//  3. Eight back-to-back beats, ready_i low cycles 3-5 -> ready_o low while stalled; all 8 results in order, none lost/duplicated.
//  4. flush_i asserted with 3 beats in flight plus valid_i high -> valid_o stays 0 for next 4 cycles; next accepted beat correct.
//  5. rst_i pulsed mid-stream, asynchronously, between edges -> outputs 0 immediately; pipe empty, no result until new input.
//  6. WIDTH=16,STAGES=2: 0x00FF+0x0001 -> 0x0100 (cross-chunk carry); STAGES=1: 0xFFFF+1 -> 0, zero_o=1, carry_o=1, 1-cycle latency.

Source files
------------

// File: rtl/addsub_pkg.sv
// addsub_pkg: shared mode encoding, default geometry and tag type for the pipelined adder/subtractor
package addsub_pkg;
    localparam int DEF_WIDTH  = 32;
    localparam int DEF_STAGES = 4;
    localparam int DEF_TAG_W  = 5;
    localparam int CW         = DEF_WIDTH / DEF_STAGES;
    typedef enum logic {MODE_ADD = 1'b0, MODE_SUB = 1'b1} mode_e;
    typedef logic [DEF_TAG_W-1:0] tag_t;
endpackage

// File: rtl/addsub_stage.sv
// addsub_stage: one chunk of the carry-pipelined adder with its carry, valid, mode and tag registers
//  en_i advances the stage, flush_i clears valid; a_i/b_i/carry_i feed the chunk adder,
//  sum_o/carry_o/msb_carry_o are the registered chunk result, the rest is registered sideband.
module addsub_stage
    import addsub_pkg::*;
#(
    parameter int CW_P  = 8,
    parameter int TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [CW_P-1:0]  a_i,
    input  logic [CW_P-1:0]  b_i,
    input  logic             carry_i,
    input  mode_e            mode_i,
    input  logic             signed_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    output logic [CW_P-1:0]  sum_o,
    output logic             carry_o,
    output logic             msb_carry_o,
    output mode_e            mode_o,
    output logic             signed_o,
    output logic [TAG_W-1:0] tag_o
);
    logic [CW_P:0] full;
    logic          msb_carry;
    always_comb begin
        full      = {1'b0, a_i} + {1'b0, b_i} + {{CW_P{1'b0}}, carry_i};
        // carry into the chunk's top bit, recovered from that bit's sum
        msb_carry = a_i[CW_P-1] ^ b_i[CW_P-1] ^ full[CW_P-1];
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o     <= 1'b0;
            sum_o       <= '0;
            carry_o     <= 1'b0;
            msb_carry_o <= 1'b0;
            mode_o      <= MODE_ADD;
            signed_o    <= 1'b0;
            tag_o       <= '0;
        end else begin
            valid_o <= ~flush_i & (en_i ? valid_i : valid_o);
            if (en_i) begin
                sum_o       <= full[CW_P-1:0];
                carry_o     <= full[CW_P];
                msb_carry_o <= msb_carry;
                mode_o      <= mode_i;
                signed_o    <= signed_i;
                tag_o       <= tag_i;
            end
        end
    end
endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: STAGES-deep carry-pipelined two's-complement adder/subtractor with valid/ready
//  inputs : clk_i, rst_i (async, high), flush_i, valid_i, src1_i, src2_i, sub_i, signed_i, tag_i, ready_i
//  outputs: ready_o, valid_o, sum_o, carry_o, overflow_o, zero_o, tag_o
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int TAG_W  = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic             sub_i,
    input  logic             signed_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             overflow_o,
    output logic             zero_o,
    output logic [TAG_W-1:0] tag_o
);
    localparam int CHUNK_W = WIDTH / STAGES;
    logic advance;
    always_comb begin
        advance = ready_i | ~valid_o;
        ready_o = advance & ~flush_i;
    end
    // a_q/b_q: operands shifted down so the chunk for stage k sits at bit 0 (timed with stage k-1 output)
    // lo_q: finished low sum chunks shifted in from the top (timed with stage k output)
    for (genvar k = 0; k < STAGES; k++) begin : g
        logic [WIDTH-1:0]   a_q, b_q, lo_q;
        logic               cin, vin, sgin;
        mode_e              mdin;
        logic [TAG_W-1:0]   tin;
        logic [CHUNK_W-1:0] s;
        logic               v, c, m, sg;
        mode_e              md;
        logic [TAG_W-1:0]   t;
        if (k == 0) begin : g_in
            assign a_q  = src1_i;
            assign b_q  = sub_i ? ~src2_i : src2_i;
            assign lo_q = '0;
            assign cin  = sub_i;
            assign vin  = valid_i & ready_o;
            assign mdin = sub_i ? MODE_SUB : MODE_ADD;
            assign sgin = signed_i;
            assign tin  = tag_i;
        end else begin : g_sk
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    a_q  <= '0;
                    b_q  <= '0;
                    lo_q <= '0;
                end else if (advance) begin
                    a_q  <= g[k-1].a_q >> CHUNK_W;
                    b_q  <= g[k-1].b_q >> CHUNK_W;
                    lo_q <= (g[k-1].lo_q >> CHUNK_W) | (WIDTH'(g[k-1].s) << (WIDTH - CHUNK_W));
                end
            end
            assign cin  = g[k-1].c;
            assign vin  = g[k-1].v;
            assign mdin = g[k-1].md;
            assign sgin = g[k-1].sg;
            assign tin  = g[k-1].t;
        end
        addsub_stage #(.CW_P(CHUNK_W), .TAG_W(TAG_W)) u_stage (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .en_i        (advance),
            .flush_i     (flush_i),
            .valid_i     (vin),
            .a_i         (a_q[CHUNK_W-1:0]),
            .b_i         (b_q[CHUNK_W-1:0]),
            .carry_i     (cin),
            .mode_i      (mdin),
            .signed_i    (sgin),
            .tag_i       (tin),
            .valid_o     (v),
            .sum_o       (s),
            .carry_o     (c),
            .msb_carry_o (m),
            .mode_o      (md),
            .signed_o    (sg),
            .tag_o       (t)
        );
    end
    always_comb begin
        valid_o    = g[STAGES-1].v;
        sum_o      = (WIDTH'(g[STAGES-1].s) << (WIDTH - CHUNK_W)) | (g[STAGES-1].lo_q >> CHUNK_W);
        carry_o    = g[STAGES-1].c;
        tag_o      = g[STAGES-1].t;
        // flags only mean something for a live result, so they read 0 out of reset and between beats
        zero_o     = valid_o & (sum_o == '0);
        overflow_o = valid_o & (g[STAGES-1].sg ? (g[STAGES-1].m ^ g[STAGES-1].c)
                                               : (g[STAGES-1].md == MODE_SUB ? ~g[STAGES-1].c : g[STAGES-1].c));
    end
endmodule
